// File: rtl/ifetch_buf.sv
// ifetch_buf: sequential instruction fetcher with a small in-order buffer.
// The pc walks memory one word per cycle while there is room. Decode sees
// the oldest buffered entry through a valid/ready handshake. A redirect
// flushes the buffer and restarts fetch at a new word-aligned address.
module ifetch_buf #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        redirect_misaligned
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [31:0]      pc;
  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  // Memory is read combinationally at the word-aligned pc; a full buffer can
  // still accept a push when the head retires in the same cycle. Head outputs
  // are forced to zero when empty so nothing stale leaks out after a flush.
  always_comb begin
    imem_addr = {pc[31:2], 2'b00};
    out_valid = (count != '0);
    pop       = out_valid && out_ready;
    push      = fetch_en && !redirect && ((count < DEPTH_CNT) || pop);
    out_pc    = out_valid ? pc_mem[rd_ptr]    : '0;
    out_instr = out_valid ? instr_mem[rd_ptr] : '0;
  end

  // Storage is not reset; it is only observed through the count-gated outputs.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= pc;
      instr_mem[wr_ptr] <= imem_data;
    end
  end

  // Control state: redirect wins over everything, otherwise push/pop move the
  // pointers and the count, and every push advances pc by one word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc                  <= {RESET_PC[31:2], 2'b00};
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      count               <= '0;
      redirect_misaligned <= 1'b0;
    end else begin
      redirect_misaligned <= redirect && (redirect_pc[1:0] != 2'b00);
      if (redirect) begin
        pc     <= {redirect_pc[31:2], 2'b00};
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          pc     <= pc + 32'd4;
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ifetch_buf.sv
// tb_ifetch_buf: directed vector table plus hand-written reset sequences
// for ifetch_buf with DEPTH=2 and RESET_PC=0.
module tb_ifetch_buf;

  typedef struct {
    logic        fe;
    logic        rd;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic        em;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        redirect_misaligned;

  int checks = 0;
  int errors = 0;
  vec_t vecs [28];

  ifetch_buf #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .fetch_en            (fetch_en),
    .redirect            (redirect),
    .redirect_pc         (redirect_pc),
    .imem_addr           (imem_addr),
    .imem_data           (imem_data),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_pc              (out_pc),
    .out_instr           (out_instr),
    .redirect_misaligned (redirect_misaligned)
  );

  // Instruction memory contents as a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[15:8], a[23:16], a[31:24]} ^ 32'h5A5A_5A5A;
  endfunction

  assign imem_data = mem_word(imem_addr);

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic fe, input logic rd, input logic [31:0] rpc,
                              input logic rdy, input logic ev, input logic [31:0] epc,
                              input logic em);
    vec_t v;
    v.fe = fe; v.rd = rd; v.rpc = rpc; v.rdy = rdy;
    v.ev = ev; v.epc = epc; v.em = em;
    return v;
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_output(input string tag, input logic ev, input logic [31:0] epc,
                              input logic em);
    compare({tag, "_valid"}, {31'd0, out_valid}, {31'd0, ev});
    compare({tag, "_pc"}, out_pc, ev ? epc : 32'd0);
    compare({tag, "_instr"}, out_instr, ev ? mem_word(epc) : 32'd0);
    compare({tag, "_mis"}, {31'd0, redirect_misaligned}, {31'd0, em});
  endtask

  // Drive inputs away from the active edge, then sample just after it.
  task automatic apply_stimulus(input logic fe, input logic rd, input logic [31:0] rpc,
                                input logic rdy);
    @(negedge clk);
    fetch_en    = fe;
    redirect    = rd;
    redirect_pc = rpc;
    out_ready   = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Streaming from reset, then backpressure for five cycles and release.
    vecs[0]  = mk(1, 0, 32'h0,         1, 1, 32'h0,         0);
    vecs[1]  = mk(1, 0, 32'h0,         1, 1, 32'h4,         0);
    vecs[2]  = mk(1, 0, 32'h0,         1, 1, 32'h8,         0);
    vecs[3]  = mk(1, 0, 32'h0,         1, 1, 32'hC,         0);
    vecs[4]  = mk(1, 0, 32'h0,         0, 1, 32'hC,         0);
    vecs[5]  = mk(1, 0, 32'h0,         0, 1, 32'hC,         0);
    vecs[6]  = mk(1, 0, 32'h0,         0, 1, 32'hC,         0);
    vecs[7]  = mk(1, 0, 32'h0,         0, 1, 32'hC,         0);
    vecs[8]  = mk(1, 0, 32'h0,         0, 1, 32'hC,         0);
    vecs[9]  = mk(1, 0, 32'h0,         1, 1, 32'h10,        0);
    vecs[10] = mk(1, 0, 32'h0,         1, 1, 32'h14,        0);
    vecs[11] = mk(1, 0, 32'h0,         1, 1, 32'h18,        0);
    // Redirect while full with a same-cycle pop request.
    vecs[12] = mk(1, 1, 32'h100,       1, 0, 32'h0,         0);
    vecs[13] = mk(1, 0, 32'h0,         1, 1, 32'h100,       0);
    vecs[14] = mk(1, 0, 32'h0,         1, 1, 32'h104,       0);
    // Misaligned redirect.
    vecs[15] = mk(1, 1, 32'h203,       1, 0, 32'h0,         1);
    vecs[16] = mk(1, 0, 32'h0,         1, 1, 32'h200,       0);
    vecs[17] = mk(1, 0, 32'h0,         1, 1, 32'h204,       0);
    // Address wrap at the top of memory.
    vecs[18] = mk(1, 1, 32'hFFFF_FFFC, 1, 0, 32'h0,         0);
    vecs[19] = mk(1, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 0);
    vecs[20] = mk(1, 0, 32'h0,         1, 1, 32'h0,         0);
    // fetch_en low: hold, then drain, pc must not have moved.
    vecs[21] = mk(0, 0, 32'h0,         0, 1, 32'h0,         0);
    vecs[22] = mk(0, 0, 32'h0,         1, 0, 32'h0,         0);
    vecs[23] = mk(0, 0, 32'h0,         1, 0, 32'h0,         0);
    vecs[24] = mk(1, 0, 32'h0,         1, 1, 32'h4,         0);
    // Misaligned redirect with fetch disabled, then resume.
    vecs[25] = mk(0, 1, 32'h42,        1, 0, 32'h0,         1);
    vecs[26] = mk(0, 0, 32'h0,         1, 0, 32'h0,         0);
    vecs[27] = mk(1, 0, 32'h0,         1, 1, 32'h40,        0);

    rst_n = 1'b0; fetch_en = 1'b1; redirect = 1'b0;
    redirect_pc = 32'h0; out_ready = 1'b1;

    // Reset state, held across a couple of edges even with fetch_en high.
    repeat (2) @(posedge clk);
    #1;
    check_output("reset", 1'b0, 32'h0, 1'b0);
    compare("reset_addr", imem_addr, 32'h0);

    @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 28; i++) begin
      apply_stimulus(vecs[i].fe, vecs[i].rd, vecs[i].rpc, vecs[i].rdy);
      check_output($sformatf("row%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].em);
    end

    // Fill the buffer with two entries, then reset asynchronously mid-cycle.
    apply_stimulus(1, 0, 32'h0, 0);
    check_output("fill", 1'b1, 32'h40, 1'b0);
    compare("fill_addr", imem_addr, 32'h48);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_rst", 1'b0, 32'h0, 1'b0);
    compare("async_rst_addr", imem_addr, 32'h0);
    @(posedge clk);
    #1;
    check_output("held_rst", 1'b0, 32'h0, 1'b0);

    // Restart from reset: first edge pushes RESET_PC, old entries never appear.
    #2 rst_n = 1'b1;
    apply_stimulus(1, 0, 32'h0, 1);
    check_output("restart0", 1'b1, 32'h0, 1'b0);
    apply_stimulus(1, 0, 32'h0, 1);
    check_output("restart1", 1'b1, 32'h4, 1'b0);
    apply_stimulus(1, 0, 32'h0, 1);
    check_output("restart2", 1'b1, 32'h8, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_buf.md
IFETCH_BUF -- requirements
Module: ifetch_buf

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address after reset (bits [1:0] SHALL be treated as zero).
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning instruction-buffer entries (power of two, >=2).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port fetch_en  input  1  fetch enable; 0 holds pc and stops pushes.
REQ-006 The block SHALL have port redirect  input  1  branch/jump/exception redirect strobe.
REQ-007 The block SHALL have port redirect_pc  input  32  new fetch address.
REQ-008 The block SHALL have port imem_addr  output  32  address to instruction memory (combinational-read).
REQ-009 The block SHALL have port imem_data  input  32  instruction returned combinationally for imem_addr.
REQ-010 The block SHALL have port out_valid  output  1  head entry valid to decode.
REQ-011 The block SHALL have port out_ready  input  1  decode accepts head entry.
REQ-012 The block SHALL have port out_pc  output  32  pc of head entry.
REQ-013 The block SHALL have port out_instr  output  32  instruction of head entry.
REQ-014 The block SHALL have port redirect_misaligned  output  1  one-cycle pulse: accepted redirect_pc had nonzero bits [1:0].

Function
REQ-015 The block SHALL hold a 32-bit pc register and drive imem_addr = {pc[31:2],2'b00} combinationally from it.
REQ-016 The block SHALL define pop = out_valid && out_ready, and push = fetch_en && !redirect && (count < DEPTH || pop).
REQ-017 On push the block SHALL write {pc, imem_data} at the tail and advance pc by 4, wrapping 32'hFFFF_FFFC to 32'h0000_0000.
REQ-018 On pop the block SHALL retire the head entry; simultaneous push and pop SHALL leave count unchanged, including when full.
REQ-019 The block SHALL drive out_valid = (count != 0) and out_pc/out_instr from the head entry, all registered-state derived (no combinational path from imem_data or out_ready).
REQ-020 While out_valid=1 and out_ready=0 and redirect=0, out_pc/out_instr SHALL remain stable.
REQ-021 On redirect=1 the block SHALL empty the buffer (count=0, pointers reset), load pc with {redirect_pc[31:2],2'b00}, push nothing, and ignore any same-cycle pop.
REQ-022 redirect_misaligned SHALL be 1 in the cycle after an accepted redirect whose redirect_pc[1:0] != 0, else 0.
REQ-023 redirect SHALL take priority over fetch_en, push and pop in the same cycle.
REQ-024 Latency: redirect sampled at edge N SHALL yield out_valid=1 with out_pc=new pc in the cycle after edge N+1, given fetch_en=1.
REQ-025 With fetch_en=0 the block SHALL keep pc constant and still allow pops to drain the buffer.
REQ-026 Buffer pointers SHALL be log2(DEPTH) bits wrapping modulo DEPTH; count SHALL be log2(DEPTH)+1 bits and never exceed DEPTH.

Reset
REQ-027 On rst_n=0, asynchronously: pc=RESET_PC with bits [1:0] cleared, count=0, pointers=0, out_valid=0, out_pc=0, out_instr=0, redirect_misaligned=0.
REQ-028 After rst_n deasserts with fetch_en=1, the first push SHALL occur at the first rising edge and out_valid SHALL assert in the following cycle with out_pc=RESET_PC.
REQ-029 Reset asserted mid-operation SHALL discard all buffered entries with no pop observable afterwards.

Verification
REQ-030 Streaming: reset, fetch_en=1, out_ready=1 -> out_pc sequence 0x0,0x4,0x8,... one per cycle, out_instr equals memory word at each.
REQ-031 Backpressure: out_ready=0 for 5 cycles -> count saturates at DEPTH, pc stops at 0x8 (DEPTH=2), out_pc held at 0x0; release -> 0x0,0x4,0x8 in order, no loss/duplication.
REQ-032 Redirect: redirect=1, redirect_pc=0x100 while buffer full -> next cycle out_valid=0, following cycle out_pc=0x100, then 0x104.
REQ-033 Misaligned redirect: redirect_pc=0x203 -> redirect_misaligned pulses 1 cycle, fetch resumes at 0x200.
REQ-034 Wrap: redirect_pc=0xFFFF_FFFC -> out_pc 0xFFFF_FFFC then 0x0000_0000.
REQ-035 Reset mid-stream with two entries buffered -> out_valid=0 immediately, restart at RESET_PC per REQ-028.
